// File: rtl/t_downcounter_if.sv
// t_downcounter_if: control and status bundle for one down-counter stage.
interface t_downcounter_if #(
    parameter int WIDTH = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             en;
    logic             bin;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             bout;
    logic             wrapped;

    modport master (
        output clear, load, d, en, bin,
        input  q, zero, bout, wrapped
    );

    modport slave (
        input  clear, load, d, en, bin,
        output q, zero, bout, wrapped
    );
endinterface

// File: rtl/t_downcounter.sv
// t_downcounter: toggle-stage down counter with load, clear, sticky underflow flag and borrow chain.
module t_downcounter #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    t_downcounter_if.slave    bus
);
    logic [WIDTH-1:0] q_q, q_d, t;
    logic             wrapped_q, wrapped_d;
    logic             cnt, zero;

    assign cnt  = bus.en & bus.bin;
    assign zero = ~|q_q;

    // bit i toggles when every lower bit is 0, which is exactly a borrow into bit i
    assign t[0] = cnt;
    for (genvar i = 1; i < WIDTH; i++) begin : g_t
        assign t[i] = t[i-1] & ~q_q[i-1];
    end

    always_comb begin
        q_d       = bus.clear ? '0 : bus.load ? bus.d : q_q ^ t;
        wrapped_d = (bus.clear | bus.load) ? 1'b0 : wrapped_q | (cnt & zero);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q       <= '0;
            wrapped_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.zero    = zero;
    assign bus.bout    = cnt & zero;
    assign bus.wrapped = wrapped_q;
endmodule

// File: tb/tb_t_downcounter.sv
// tb_t_downcounter: directed checks of one 4-bit stage plus a two-stage cascade against a q-1 model.
module tb_t_downcounter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    t_downcounter_if #(.WIDTH(4)) a ();
    t_downcounter_if #(.WIDTH(4)) b0 ();
    t_downcounter_if #(.WIDTH(4)) b1 ();

    t_downcounter #(.WIDTH(4)) u_a  (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    t_downcounter #(.WIDTH(4)) u_b0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    t_downcounter #(.WIDTH(4)) u_b1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    logic [7:0] cd;
    assign b0.d     = cd[3:0];
    assign b1.d     = cd[7:4];
    assign b1.clear = b0.clear;
    assign b1.load  = b0.load;
    assign b1.en    = b0.en;
    assign b1.bin   = b0.bout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic c, input logic l, input logic e, input logic b, input logic [3:0] dv);
        a.clear = c;
        a.load  = l;
        a.en    = e;
        a.bin   = b;
        a.d     = dv;
    endtask

    task automatic cdrv(input logic c, input logic l, input logic e, input logic [7:0] dv);
        b0.clear = c;
        b0.load  = l;
        b0.en    = e;
        cd       = dv;
    endtask

    initial begin
        logic [3:0] exp_q [7] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
        logic [7:0] m;
        logic       wl, wh;
        logic       rc, rl, re;
        logic [7:0] rd;
        drv(0, 0, 0, 1, 0);
        b0.bin = 1'b1;
        cdrv(0, 0, 0, 8'h00);
        #2;
        chk("rst_q", a.q, 0);
        chk("rst_zero", a.zero, 1);
        #10 rst_n = 1'b1;

        drv(0, 1, 0, 1, 4'hA);
        step();
        chk("ld_a", a.q, 4'hA);
        #3 rst_n = 1'b0;
        #1;
        chk("async_q", a.q, 0);
        chk("async_wr", a.wrapped, 0);
        chk("async_zero", a.zero, 1);
        drv(0, 0, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_hold_q", a.q, 0);
            chk("rst_bout", a.bout, 1);
        end
        rst_n = 1'b1;
        step();
        chk("post_rst_q", a.q, 15);
        chk("post_rst_wr", a.wrapped, 1);

        drv(0, 1, 1, 1, 4'd5);
        step();
        chk("ld5_q", a.q, 5);
        chk("ld5_wr", a.wrapped, 0);
        chk("ld5_bout", a.bout, 0);
        drv(0, 0, 1, 1, 0);
        for (int k = 0; k < 7; k++) begin
            step();
            chk("cd_q", a.q, exp_q[k]);
            chk("cd_zero", a.zero, exp_q[k] == 0);
            chk("cd_bout", a.bout, exp_q[k] == 0);
            chk("cd_wr", a.wrapped, k >= 5);
        end

        drv(0, 1, 0, 1, 4'd9);
        step();
        chk("ld9", a.q, 9);
        drv(1, 1, 1, 1, 4'd3);
        step();
        chk("clr_wins", a.q, 0);
        drv(0, 1, 1, 1, 4'd3);
        step();
        chk("ld_wins", a.q, 3);
        chk("ld_wins_wr", a.wrapped, 0);

        drv(0, 1, 0, 1, 4'd7);
        step();
        drv(0, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bin0_q", a.q, 7);
            chk("bin0_bout", a.bout, 0);
        end
        drv(0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("en0_q", a.q, 7);
        end

        drv(0, 1, 0, 1, 4'd0);
        step();
        drv(0, 0, 1, 1, 0);
        step();
        chk("wrap_q", a.q, 15);
        chk("wrap_wr", a.wrapped, 1);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("sticky_q", a.q, (15 - k) & 15);
            chk("sticky_wr", a.wrapped, 1);
        end
        drv(1, 0, 1, 1, 0);
        step();
        chk("clr_q", a.q, 0);
        chk("clr_wr", a.wrapped, 0);
        drv(0, 0, 1, 1, 0);
        step();
        chk("rewrap_wr", a.wrapped, 1);
        drv(0, 1, 1, 1, 4'd2);
        step();
        chk("ld2_q", a.q, 2);
        chk("ld2_wr", a.wrapped, 0);
        drv(0, 1, 1, 1, 4'd0);
        step();
        chk("ld0_q", a.q, 0);
        chk("ld0_wr", a.wrapped, 0);

        cdrv(0, 1, 0, 8'h10);
        step();
        chk("c_ld10", {b1.q, b0.q}, 8'h10);
        cdrv(0, 0, 1, 0);
        step();
        chk("c_0f", {b1.q, b0.q}, 8'h0F);
        step();
        chk("c_0e", {b1.q, b0.q}, 8'h0E);
        step();
        chk("c_0d", {b1.q, b0.q}, 8'h0D);
        cdrv(0, 1, 0, 8'h00);
        step();
        cdrv(0, 0, 1, 0);
        step();
        chk("c_ff", {b1.q, b0.q}, 8'hFF);
        chk("c_wr0", b0.wrapped, 1);
        chk("c_wr1", b1.wrapped, 1);

        m  = 8'hFF;
        wl = 1'b1;
        wh = 1'b1;
        for (int k = 0; k < 300; k++) begin
            rc = ($urandom_range(0, 19) == 0);
            rl = ($urandom_range(0, 9) == 0);
            re = ($urandom_range(0, 3) != 0);
            rd = 8'($urandom);
            cdrv(rc, rl, re, rd);
            if (rc) begin
                m = 0; wl = 0; wh = 0;
            end else if (rl) begin
                m = rd; wl = 0; wh = 0;
            end else if (re) begin
                wl = wl | (m[3:0] == 0);
                wh = wh | (m == 0);
                m  = m - 8'd1;
            end
            step();
            chk("rnd_q", {b1.q, b0.q}, m);
            chk("rnd_wr0", b0.wrapped, wl);
            chk("rnd_wr1", b1.wrapped, wh);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
